// File: rtl/handshake_constant_burst.sv
// Turns each accepted ctrl token into REPEAT registered beats of CONST_VALUE, tagged 0..REPEAT-1.
// Define HANDSHAKE_CONSTANT_BURST_LAST_EN to add the registered outs_last marker on the final beat.
module handshake_constant_burst #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
  parameter int unsigned           REPEAT      = 1,
  parameter int unsigned           IDX_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_idx,
  output logic                  outs_valid,
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
  output logic                  outs_last,
`endif
  input  logic                  outs_ready
);

  if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
    $error("handshake_constant_burst: REPEAT must be in 1..65535");
  end
  if (IDX_WIDTH < 1 || (IDX_WIDTH < 17 && (32'd1 << IDX_WIDTH) < REPEAT)) begin : g_bad_idx_width
    $error("handshake_constant_burst: IDX_WIDTH too narrow for REPEAT");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REPEAT - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t               r_state;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 w_valid;
  logic                 w_at_last;
  logic                 w_ctrl_fire;
  logic                 w_outs_fire;

  assign w_valid     = (r_state == EMIT);
  assign w_at_last   = (r_idx == LAST_IDX);
  // Gating with rst keeps ctrl_ready low (and X-free) for the whole reset window.
  assign ctrl_ready  = rst & (~w_valid | (outs_ready & w_at_last));
  assign w_ctrl_fire = ctrl_valid & ctrl_ready;
  assign w_outs_fire = w_valid & outs_ready;

  assign outs_valid  = w_valid;
  assign outs        = w_valid ? CONST_VALUE : '0;
  assign outs_idx    = r_idx;

`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
  logic r_last;
  assign outs_last = r_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
      r_last  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ctrl_fire) begin
            r_state <= EMIT;
            r_idx   <= '0;
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
            r_last  <= (LAST_IDX == '0);
`endif
          end
        end
        EMIT: begin
          if (w_outs_fire) begin
            if (w_at_last) begin
              r_idx <= '0;
              // A token waiting on the last beat restarts the burst with no bubble.
              if (w_ctrl_fire) begin
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
                r_last  <= (LAST_IDX == '0);
`endif
              end else begin
                r_state <= IDLE;
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
                r_last  <= 1'b0;
`endif
              end
            end else begin
              r_idx  <= r_idx + 1'b1;
`ifdef HANDSHAKE_CONSTANT_BURST_LAST_EN
              r_last <= ((r_idx + 1'b1) == LAST_IDX);
`endif
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
